// File: rtl/record_track.sv
// Note recorder: synchronizes note keys, times each held {octave, note} symbol in
// length units and stores {octave, note, length} entries. Optional RECORD_DEBOUNCE_EN.
module record_track #(
    parameter int DEPTH          = 64,
    parameter int UNIT_TICKS     = 12_500_000,
    parameter int DEBOUNCE_TICKS = 1_000_000
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       en,
    input  logic [6:0]                 keys,
    input  logic [1:0]                 octave,
    input  logic [$clog2(DEPTH)-1:0]   rd_addr,
    output logic [8:0]                 rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       recording,
    output logic [6:0]                 led
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(UNIT_TICKS + 1);

    typedef enum logic [2:0] {IDLE, ARM, HOLD, COMMIT, DONE} state_t;

    function automatic logic [2:0] lowest_note(input logic [6:0] k);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 6; i >= 0; i--) begin
            if (k[i]) n = 3'(i + 1);
        end
        return n;
    endfunction

    function automatic logic [6:0] note_led(input logic [2:0] n);
        logic [6:0] l;
        l = 7'd0;
        if (n != 3'd0) l[n - 3'd1] = 1'b1;
        else           l = 7'd0;
        return l;
    endfunction

    logic [6:0]    sync1_r, sync2_r, acc_keys_s;
    logic [2:0]    acc_note_s;
    logic [4:0]    acc_sym_s;
    state_t        state_r;
    logic [4:0]    held_sym_r;
    logic [3:0]    len_r;
    logic [TW-1:0] tick_r;
    logic          en_d_r;
    logic [CW-1:0] count_r;
    logic          full_r, recording_r;
    logic [6:0]    led_r;
    logic [8:0]    rd_data_r;
    logic          we_s, last_slot_s;
    logic [8:0]    wr_data_s;
    logic [8:0]    mem [DEPTH];

    // Two-flop synchronizer for the asynchronous key inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r <= 7'd0;
            sync2_r <= 7'd0;
        end else begin
            sync1_r <= keys;
            sync2_r <= sync1_r;
        end
    end

`ifdef RECORD_DEBOUNCE_EN
    localparam int DW = $clog2(DEBOUNCE_TICKS + 1);
    logic [6:0]    deb_last_r, deb_keys_r;
    logic [DW-1:0] deb_cnt_r;

    // Accept a synchronized key vector only after it has stayed unchanged long enough.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deb_last_r <= 7'd0;
            deb_keys_r <= 7'd0;
            deb_cnt_r  <= '0;
        end else if (sync2_r != deb_last_r) begin
            deb_last_r <= sync2_r;
            deb_cnt_r  <= '0;
        end else if (deb_cnt_r == DW'(DEBOUNCE_TICKS - 1)) begin
            deb_keys_r <= deb_last_r;
        end else begin
            deb_cnt_r <= deb_cnt_r + DW'(1);
        end
    end
    assign acc_keys_s = deb_keys_r;
`else
    assign acc_keys_s = sync2_r;
    // DEBOUNCE_TICKS has no role when keys are accepted straight from the synchronizer.
    if (DEBOUNCE_TICKS < 1) begin : g_no_debounce
    end
`endif

    assign acc_note_s  = lowest_note(acc_keys_s);
    assign acc_sym_s   = {octave, acc_note_s};
    assign last_slot_s = (count_r == CW'(DEPTH - 1));
    assign wr_data_s   = {held_sym_r, len_r};

    // Write strobe: every COMMIT, and on take end only for a non-rest held symbol.
    always_comb begin
        we_s = 1'b0;
        case (state_r)
            HOLD: begin
                if (!en && (held_sym_r[2:0] != 3'd0)) we_s = 1'b1;
                else                                   we_s = 1'b0;
            end
            COMMIT:  we_s = 1'b1;
            default: we_s = 1'b0;
        endcase
        if (count_r == CW'(DEPTH)) we_s = 1'b0;
        else                       we_s = we_s;
    end

    // Take control FSM with registered status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IDLE;
            held_sym_r  <= 5'd0;
            len_r       <= 4'd0;
            tick_r      <= '0;
            en_d_r      <= 1'b1;
            count_r     <= '0;
            full_r      <= 1'b0;
            recording_r <= 1'b0;
            led_r       <= 7'd0;
        end else begin
            en_d_r <= en;
            led_r  <= note_led(acc_note_s);
            if (we_s) count_r <= count_r + CW'(1);
            case (state_r)
                IDLE: begin
                    if (en && !en_d_r) begin
                        count_r     <= '0;
                        full_r      <= 1'b0;
                        recording_r <= 1'b1;
                        state_r     <= ARM;
                    end
                end
                ARM: begin
                    if (!en) begin
                        recording_r <= 1'b0;
                        state_r     <= DONE;
                    end else if (acc_note_s != 3'd0) begin
                        held_sym_r <= acc_sym_s;
                        len_r      <= 4'd1;
                        tick_r     <= '0;
                        state_r    <= HOLD;
                    end
                end
                HOLD: begin
                    if (!en) begin
                        full_r      <= we_s && last_slot_s;
                        recording_r <= 1'b0;
                        state_r     <= DONE;
                    end else if (acc_sym_s != held_sym_r) begin
                        recording_r <= 1'b0;
                        state_r     <= COMMIT;
                    end else if (tick_r == TW'(UNIT_TICKS - 1)) begin
                        tick_r <= '0;
                        len_r  <= len_r + 4'd1;
                        // Length saturates at 15 units: flush and continue as a new entry.
                        if (len_r == 4'd14) begin
                            recording_r <= 1'b0;
                            state_r     <= COMMIT;
                        end
                    end else begin
                        tick_r <= tick_r + TW'(1);
                    end
                end
                COMMIT: begin
                    held_sym_r <= acc_sym_s;
                    len_r      <= 4'd1;
                    tick_r     <= '0;
                    if (last_slot_s) begin
                        full_r  <= 1'b1;
                        state_r <= DONE;
                    end else begin
                        recording_r <= 1'b1;
                        state_r     <= HOLD;
                    end
                end
                DONE: begin
                    if (!en) state_r <= IDLE;
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    // Entry storage; contents survive reset.
    always_ff @(posedge clk) begin
        if (we_s) mem[count_r[AW-1:0]] <= wr_data_s;
    end

    // Registered read port; a same-cycle write is seen on the following read.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_data_r <= 9'd0;
        else        rd_data_r <= mem[rd_addr];
    end

    assign rd_data   = rd_data_r;
    assign count     = count_r;
    assign full      = full_r;
    assign recording = recording_r;
    assign led       = led_r;
endmodule
